// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - divided clock generator with a glitch-safe clock-select handshake
// Optional feature macro: CLKDIV_EARLY_SWITCH_EN (apply select changes at the first safe tick, not only on wrap)
module clk_div_gen #(
    parameter int BASE_DIV = 50,
    parameter int PRESC_W  = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] freq_req,
    input  logic       freq_load,
    output logic       CLK8,
    output logic       CLK4,
    output logic       CLK2,
    output logic       CLK1,
    output logic [1:0] clk_freq,
    output logic       busy
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(BASE_DIV - 1);

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] presc;
    logic [3:0]         p;
    logic [3:0]         p_nxt;
    logic [1:0]         pending, pending_nxt;
    logic [1:0]         clk_freq_nxt;
    logic               tick;
    logic               apply_ok;

    assign tick  = EN && (presc == PRESC_MAX);
    assign p_nxt = p + 4'd1;

`ifdef CLKDIV_EARLY_SWITCH_EN
    logic [1:0] sel_cur;
    logic [1:0] sel_tgt;

    // clk_freq value v selects p[3-v]; both the old and new clock must be low after the tick
    assign sel_cur  = 2'd3 - clk_freq;
    assign sel_tgt  = 2'd3 - pending;
    assign apply_ok = tick && !p_nxt[sel_cur] && !p_nxt[sel_tgt];
`else
    assign apply_ok = tick && (p == 4'hF);
`endif

    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        clk_freq_nxt = clk_freq;
        case (state)
            IDLE: begin
                if (freq_load) begin
                    pending_nxt = freq_req;
                    state_nxt   = PEND;
                end
            end
            PEND: begin
                if (apply_ok) begin
                    clk_freq_nxt = pending;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc    <= '0;
            p        <= 4'h0;
            state    <= IDLE;
            pending  <= 2'b00;
            clk_freq <= 2'b00;
        end else begin
            if (tick) begin
                presc <= '0;
                p     <= p_nxt;
            end else if (EN) begin
                presc <= presc + 1'b1;
            end
            state    <= state_nxt;
            pending  <= pending_nxt;
            clk_freq <= clk_freq_nxt;
        end
    end

    assign CLK8 = p[0];
    assign CLK4 = p[1];
    assign CLK2 = p[2];
    assign CLK1 = p[3];
    assign busy = (state == PEND);

endmodule
